// File: rtl/div_rs_if.sv
// Instruction payload types and the dispatch/wakeup/issue bundle of the divide reservation station.
`timescale 1ns/1ps
package div_rs_pkg;
  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } r_type_t;

  typedef union packed {
    r_type_t     r_type;
    logic [31:0] raw;
  } instr_data_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    instr_data_t data;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
  } ooo_instr_t;
endpackage

interface div_rs_if #(parameter int PHYS_REG_BITS = 6);
  import div_rs_pkg::*;
  logic                     flush;
  logic                     dispatch_valid;
  ooo_instr_t               dispatch_instr;
  logic [PHYS_REG_BITS-1:0] dispatch_ps1;
  logic [PHYS_REG_BITS-1:0] dispatch_ps2;
  logic                     dispatch_ps1_rdy;
  logic                     dispatch_ps2_rdy;
  logic                     rs_full;
  logic                     cdb_valid;
  logic [PHYS_REG_BITS-1:0] cdb_pd;
  logic [31:0]              cdb_data;
  logic                     fu_busy;
  ooo_instr_t               issue_instr;
  logic                     issue_ready;

  modport master (
    output flush, dispatch_valid, dispatch_instr, dispatch_ps1, dispatch_ps2,
           dispatch_ps1_rdy, dispatch_ps2_rdy, cdb_valid, cdb_pd, cdb_data, fu_busy,
    input  rs_full, issue_instr, issue_ready
  );
  modport slave (
    input  flush, dispatch_valid, dispatch_instr, dispatch_ps1, dispatch_ps2,
           dispatch_ps1_rdy, dispatch_ps2_rdy, cdb_valid, cdb_pd, cdb_data, fu_busy,
    output rs_full, issue_instr, issue_ready
  );
endinterface

// File: rtl/div_rs.sv
// Collapsing in-order reservation station for the divide unit: tag wakeup from the CDB,
// oldest-ready select, registered single-cycle issue strobe.
`timescale 1ns/1ps
module div_rs_wake #(
  parameter int PHYS_REG_BITS = 6
) (
  input  logic                     cur_rdy,
  input  logic [PHYS_REG_BITS-1:0] ps,
  input  logic [31:0]              cur_data,
  input  logic                     cdb_valid,
  input  logic [PHYS_REG_BITS-1:0] cdb_pd,
  input  logic [31:0]              cdb_data,
  output logic                     nxt_rdy,
  output logic [31:0]              nxt_data
);
  logic hit;
  assign hit      = cdb_valid && !cur_rdy && (ps == cdb_pd);
  assign nxt_rdy  = cur_rdy | hit;
  assign nxt_data = hit ? cdb_data : cur_data;
endmodule

module div_rs
  import div_rs_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int PHYS_REG_BITS = 6
) (
  input logic    clk,
  input logic    rst,
  div_rs_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  ooo_instr_t               ent   [DEPTH];
  ooo_instr_t               n_ent [DEPTH];
  logic [PHYS_REG_BITS-1:0] ps1   [DEPTH];
  logic [PHYS_REG_BITS-1:0] ps2   [DEPTH];
  logic [PHYS_REG_BITS-1:0] n_ps1 [DEPTH];
  logic [PHYS_REG_BITS-1:0] n_ps2 [DEPTH];
  logic [31:0]              w_d1  [DEPTH];
  logic [31:0]              w_d2  [DEPTH];
  logic [DEPTH-1:0]         rdy1, rdy2, n_rdy1, n_rdy2, w_rdy1, w_rdy2, elig;
  logic [CW-1:0]            count, cnt_after, n_count;
  logic [IW-1:0]            sel;
  logic                     sel_hit, issue_go, accept;
  logic                     d_rdy1, d_rdy2;
  logic [31:0]              d_d1, d_d2;
  ooo_instr_t               issue_q, n_issue;

  assign bus.rs_full     = (count == CW'(DEPTH));
  assign bus.issue_instr = issue_q;
  assign bus.issue_ready = issue_q.valid;

  // Per-entry wakeup view: what each slot looks like after this cycle's broadcast.
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    div_rs_wake #(.PHYS_REG_BITS(PHYS_REG_BITS)) u_w1 (
      .cur_rdy(rdy1[g]), .ps(ps1[g]), .cur_data(ent[g].rs1_data),
      .cdb_valid(bus.cdb_valid), .cdb_pd(bus.cdb_pd), .cdb_data(bus.cdb_data),
      .nxt_rdy(w_rdy1[g]), .nxt_data(w_d1[g]));
    div_rs_wake #(.PHYS_REG_BITS(PHYS_REG_BITS)) u_w2 (
      .cur_rdy(rdy2[g]), .ps(ps2[g]), .cur_data(ent[g].rs2_data),
      .cdb_valid(bus.cdb_valid), .cdb_pd(bus.cdb_pd), .cdb_data(bus.cdb_data),
      .nxt_rdy(w_rdy2[g]), .nxt_data(w_d2[g]));
  end

  // Incoming operands see the same broadcast so a same-cycle result is never lost.
  div_rs_wake #(.PHYS_REG_BITS(PHYS_REG_BITS)) u_wd1 (
    .cur_rdy(bus.dispatch_ps1_rdy), .ps(bus.dispatch_ps1),
    .cur_data(bus.dispatch_ps1_rdy ? bus.dispatch_instr.rs1_data : 32'd0),
    .cdb_valid(bus.cdb_valid), .cdb_pd(bus.cdb_pd), .cdb_data(bus.cdb_data),
    .nxt_rdy(d_rdy1), .nxt_data(d_d1));
  div_rs_wake #(.PHYS_REG_BITS(PHYS_REG_BITS)) u_wd2 (
    .cur_rdy(bus.dispatch_ps2_rdy), .ps(bus.dispatch_ps2),
    .cur_data(bus.dispatch_ps2_rdy ? bus.dispatch_instr.rs2_data : 32'd0),
    .cdb_valid(bus.cdb_valid), .cdb_pd(bus.cdb_pd), .cdb_data(bus.cdb_data),
    .nxt_rdy(d_rdy2), .nxt_data(d_d2));

  // Select looks only at registered ready bits; a wakeup counts from the next cycle.
  always_comb begin
    elig    = '0;
    sel     = '0;
    sel_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      elig[i] = rdy1[i] && rdy2[i] && (CW'(i) < count);
    for (int i = DEPTH - 1; i >= 0; i--)
      if (elig[i]) begin
        sel     = IW'(i);
        sel_hit = 1'b1;
      end
  end

  assign issue_go = sel_hit && !bus.fu_busy && !issue_q.valid;

  always_comb begin
    int src;
    src    = 0;
    n_ent  = ent;
    n_ps1  = ps1;
    n_ps2  = ps2;
    n_rdy1 = rdy1;
    n_rdy2 = rdy2;
    for (int i = 0; i < DEPTH; i++) begin
      src = (issue_go && (IW'(i) >= sel)) ? i + 1 : i;
      if (src < DEPTH) begin
        n_ent[i]          = ent[IW'(src)];
        n_ent[i].rs1_data = w_d1[IW'(src)];
        n_ent[i].rs2_data = w_d2[IW'(src)];
        n_ps1[i]          = ps1[IW'(src)];
        n_ps2[i]          = ps2[IW'(src)];
        n_rdy1[i]         = w_rdy1[IW'(src)];
        n_rdy2[i]         = w_rdy2[IW'(src)];
      end else begin
        n_rdy1[i] = 1'b0;
        n_rdy2[i] = 1'b0;
      end
    end
    cnt_after = count - CW'(issue_go);
    accept    = bus.dispatch_valid && !bus.rs_full;
    if (accept) begin
      n_ent[IW'(cnt_after)]          = bus.dispatch_instr;
      n_ent[IW'(cnt_after)].rs1_data = d_d1;
      n_ent[IW'(cnt_after)].rs2_data = d_d2;
      n_ps1[IW'(cnt_after)]          = bus.dispatch_ps1;
      n_ps2[IW'(cnt_after)]          = bus.dispatch_ps2;
      n_rdy1[IW'(cnt_after)]         = d_rdy1;
      n_rdy2[IW'(cnt_after)]         = d_rdy2;
    end
    n_count = cnt_after + CW'(accept);
    n_issue = '0;
    if (issue_go) begin
      n_issue       = ent[sel];
      n_issue.valid = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    ent <= n_ent;
    ps1 <= n_ps1;
    ps2 <= n_ps2;
    if (rst || bus.flush) begin
      count   <= '0;
      rdy1    <= '0;
      rdy2    <= '0;
      issue_q <= '0;
    end else begin
      count   <= n_count;
      rdy1    <= n_rdy1;
      rdy2    <= n_rdy2;
      issue_q <= n_issue;
    end
  end
endmodule
